// File: rtl/sw_alloc_rr.sv
// sw_alloc_rr: switch allocator for one 5-port mesh router.
// Each output is owned by a small IDLE/LOCKED FSM. In IDLE it picks among
// head flits round-robin. In LOCKED it serves only the packet owner until
// that owner sends its tail flit or stays idle for LOCK_TIMEOUT cycles.
// Grants and crossbar selects are combinational. Error and timeout flags
// are registered one-cycle pulses.
module sw_alloc_rr #(
  parameter int unsigned LOCK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  req_valid,
  input  logic [14:0] req_gate,
  input  logic [9:0]  req_type,
  input  logic [4:0]  out_ready,
  output logic [4:0]  grant,
  output logic [4:0]  xbar_valid,
  output logic [14:0] xbar_sel,
  output logic [4:0]  err_gate,
  output logic [4:0]  err_order,
  output logic [4:0]  lock_tmo
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(LOCK_TIMEOUT);
  localparam logic [1:0] T_HEAD    = 2'b00;
  localparam logic [1:0] T_TAIL    = 2'b10;

  state_t     state_r [5];
  logic [2:0] owner_r [5];
  logic [2:0] ptr_r   [5];
  logic [7:0] cnt_r   [5];
  logic [4:0] err_gate_r;
  logic [4:0] err_order_r;
  logic [4:0] lock_tmo_r;

  logic [2:0] gate_s [5];
  logic [1:0] type_s [5];
  logic [4:0] legal_s;
  logic [4:0] head_s;
  logic [4:0] err_gate_s;
  logic [4:0] err_order_s;
  logic [4:0] ovalid_s;
  logic [2:0] win_s [5];
  logic [4:0] own_req_s;
  logic [4:0] grant_s;

  // (base + k) mod 5 for the round-robin scan and pointer advance
  function automatic logic [2:0] rr_add(input logic [2:0] base, input logic [2:0] k);
    logic [3:0] sum;
    sum = {1'b0, base} + {1'b0, k};
    if (sum >= 4'd5) begin
      rr_add = 3'(sum - 4'd5);
    end else begin
      rr_add = sum[2:0];
    end
  endfunction

  // Unpack per-input fields and classify flit types and gate legality
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      gate_s[i]     = req_gate[3*i +: 3];
      type_s[i]     = req_type[2*i +: 2];
      legal_s[i]    = (gate_s[i] < 3'd5);
      head_s[i]     = (type_s[i] == 2'b00) || (type_s[i] == 2'b11);
      err_gate_s[i] = req_valid[i] && !legal_s[i];
    end
  end

  // Flag order errors: body/tail to an output not owned by the sender, or head from the current owner
  always_comb begin
    err_order_s = 5'd0;
    for (int i = 0; i < 5; i++) begin
      for (int o = 0; o < 5; o++) begin
        if (req_valid[i] && legal_s[i] && (gate_s[i] == 3'(o))) begin
          if ((state_r[o] == LOCKED) && (owner_r[o] == 3'(i))) begin
            err_order_s[i] = err_order_s[i] | head_s[i];
          end else begin
            err_order_s[i] = err_order_s[i] | !head_s[i];
          end
        end else begin
          err_order_s[i] = err_order_s[i];
        end
      end
    end
  end

  // Per-output arbitration: round-robin among heads when IDLE, owner-only when LOCKED
  always_comb begin
    ovalid_s  = 5'd0;
    own_req_s = 5'd0;
    grant_s   = 5'd0;
    for (int o = 0; o < 5; o++) begin
      win_s[o] = 3'd0;
      if (state_r[o] == IDLE) begin
        if (out_ready[o]) begin
          for (int k = 0; k < 5; k++) begin
            if (!ovalid_s[o] && req_valid[rr_add(ptr_r[o], 3'(k))] &&
                (gate_s[rr_add(ptr_r[o], 3'(k))] == 3'(o)) &&
                head_s[rr_add(ptr_r[o], 3'(k))]) begin
              ovalid_s[o] = 1'b1;
              win_s[o]    = rr_add(ptr_r[o], 3'(k));
            end else begin
              ovalid_s[o] = ovalid_s[o];
            end
          end
        end else begin
          ovalid_s[o] = 1'b0;
        end
      end else begin
        own_req_s[o] = req_valid[owner_r[o]] && (gate_s[owner_r[o]] == 3'(o));
        if (own_req_s[o] && !head_s[owner_r[o]] && out_ready[o]) begin
          ovalid_s[o] = 1'b1;
          win_s[o]    = owner_r[o];
        end else begin
          ovalid_s[o] = 1'b0;
        end
      end
      for (int i = 0; i < 5; i++) begin
        grant_s[i] = grant_s[i] | (ovalid_s[o] && (win_s[o] == 3'(i)));
      end
    end
  end

  // Drive crossbar controls; everything is forced low while reset is held
  always_comb begin
    grant      = 5'd0;
    xbar_valid = 5'd0;
    xbar_sel   = 15'd0;
    if (!reset) begin
      grant      = grant_s;
      xbar_valid = ovalid_s;
      for (int o = 0; o < 5; o++) begin
        if (ovalid_s[o]) begin
          xbar_sel[3*o +: 3] = win_s[o];
        end else begin
          xbar_sel[3*o +: 3] = 3'd0;
        end
      end
    end else begin
      grant      = 5'd0;
      xbar_valid = 5'd0;
      xbar_sel   = 15'd0;
    end
  end

  // Output FSMs, round-robin pointers, lock timeout counters and error pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int o = 0; o < 5; o++) begin
        state_r[o] <= IDLE;
        owner_r[o] <= 3'd0;
        ptr_r[o]   <= 3'd0;
        cnt_r[o]   <= 8'd0;
      end
      err_gate_r  <= 5'd0;
      err_order_r <= 5'd0;
      lock_tmo_r  <= 5'd0;
    end else begin
      err_gate_r  <= err_gate_s;
      err_order_r <= err_order_s;
      for (int o = 0; o < 5; o++) begin
        lock_tmo_r[o] <= 1'b0;
        if (state_r[o] == IDLE) begin
          if (ovalid_s[o]) begin
            ptr_r[o] <= rr_add(win_s[o], 3'd1);
            if (type_s[win_s[o]] == T_HEAD) begin
              state_r[o] <= LOCKED;
              owner_r[o] <= win_s[o];
            end else begin
              state_r[o] <= IDLE;
            end
          end else begin
            ptr_r[o] <= ptr_r[o];
          end
          cnt_r[o] <= 8'd0;
        end else begin
          if (ovalid_s[o]) begin
            cnt_r[o] <= 8'd0;
            if (type_s[owner_r[o]] == T_TAIL) begin
              state_r[o] <= IDLE;
            end else begin
              state_r[o] <= LOCKED;
            end
          end else if (!own_req_s[o]) begin
            // saturating increment; release once the idle run reaches the limit
            if (((cnt_r[o] == 8'hFF) ? 8'hFF : (cnt_r[o] + 8'd1)) >= TMO_LIMIT) begin
              state_r[o]    <= IDLE;
              cnt_r[o]      <= 8'd0;
              lock_tmo_r[o] <= 1'b1;
            end else begin
              cnt_r[o] <= cnt_r[o] + 8'd1;
            end
          end else begin
            cnt_r[o] <= cnt_r[o];
          end
        end
      end
    end
  end

  assign err_gate  = err_gate_r;
  assign err_order = err_order_r;
  assign lock_tmo  = lock_tmo_r;

endmodule

// File: tb/tb_sw_alloc_rr.sv
// Directed testbench for sw_alloc_rr (LOCK_TIMEOUT = 4).
// Inputs change 1 ns after a rising edge. Outputs are checked 1 ns later.
module tb_sw_alloc_rr;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  req_valid = 5'd0;
  logic [14:0] req_gate = 15'd0;
  logic [9:0]  req_type = 10'd0;
  logic [4:0]  out_ready = 5'h1F;
  logic [4:0]  grant;
  logic [4:0]  xbar_valid;
  logic [14:0] xbar_sel;
  logic [4:0]  err_gate;
  logic [4:0]  err_order;
  logic [4:0]  lock_tmo;

  int vectors = 0;
  int miscompares = 0;

  sw_alloc_rr #(.LOCK_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_gate(req_gate),
    .req_type(req_type), .out_ready(out_ready), .grant(grant),
    .xbar_valid(xbar_valid), .xbar_sel(xbar_sel), .err_gate(err_gate),
    .err_order(err_order), .lock_tmo(lock_tmo)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [2:0] g, input logic [1:0] t);
    req_valid[i]      = 1'b1;
    req_gate[3*i +: 3] = g;
    req_type[2*i +: 2] = t;
  endtask

  task automatic clr_req(input int i);
    req_valid[i] = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    reset = 1'b1;
    req_valid = 5'd0;
    out_ready = 5'h1F;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(0, 3'd3, 2'b11);
    #1;
    vectors++;
    if (grant !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_grant: got %b want %b", grant, 5'd0);
    end
    vectors++;
    if (xbar_valid !== 5'd0 || xbar_sel !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_xbar: got %b/%h want 0/0", xbar_valid, xbar_sel);
    end
    vectors++;
    if ({err_gate, err_order, lock_tmo} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_flags: got %h want 0", {err_gate, err_order, lock_tmo});
    end
    do_reset();
  endtask

  task automatic test_single();
    set_req(0, 3'd3, 2'b11);
    #1;
    vectors++;
    if (grant !== 5'b00001) begin
      miscompares++;
      $display("FAIL single_grant: got %b want %b", grant, 5'b00001);
    end
    vectors++;
    if (xbar_valid !== 5'b01000 || xbar_sel !== 15'd0) begin
      miscompares++;
      $display("FAIL single_xbar: got %b/%h want 01000/0000", xbar_valid, xbar_sel);
    end
    next_cycle();
    clr_req(0);
    set_req(1, 3'd3, 2'b11);
    #1;
    vectors++;
    if (grant !== 5'b00010) begin
      miscompares++;
      $display("FAIL single_stays_idle: got %b want %b", grant, 5'b00010);
    end
    next_cycle();
    req_valid = 5'd0;
  endtask

  task automatic test_contention();
    logic [4:0]  exp_g [3];
    logic [14:0] exp_s [3];
    exp_g[0] = 5'b00010; exp_s[0] = 15'd1;
    exp_g[1] = 5'b00100; exp_s[1] = 15'd2;
    exp_g[2] = 5'b10000; exp_s[2] = 15'd4;
    do_reset();
    set_req(1, 3'd0, 2'b11);
    set_req(2, 3'd0, 2'b11);
    set_req(4, 3'd0, 2'b11);
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (grant !== exp_g[c] || xbar_sel !== exp_s[c]) begin
        miscompares++;
        $display("FAIL contention_c%0d: got %b/%h want %b/%h", c, grant, xbar_sel, exp_g[c], exp_s[c]);
      end
      next_cycle();
      req_valid = req_valid & ~exp_g[c];
    end
    set_req(0, 3'd0, 2'b11);
    set_req(1, 3'd0, 2'b11);
    #1;
    vectors++;
    if (grant !== 5'b00001) begin
      miscompares++;
      $display("FAIL contention_ptr_wrap: got %b want %b", grant, 5'b00001);
    end
    next_cycle();
    req_valid = 5'd0;
  endtask

  task automatic test_wormhole();
    logic [1:0] seq [3];
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b10;
    do_reset();
    set_req(3, 3'd1, 2'b00);
    for (int c = 0; c < 3; c++) begin
      set_req(2, 3'd1, seq[c]);
      #1;
      vectors++;
      if (grant !== 5'b00100 || xbar_sel !== 15'h0010) begin
        miscompares++;
        $display("FAIL wormhole_c%0d: got %b/%h want 00100/0010", c, grant, xbar_sel);
      end
      next_cycle();
    end
    clr_req(2);
    #1;
    vectors++;
    if (grant !== 5'b01000 || xbar_sel !== 15'h0018) begin
      miscompares++;
      $display("FAIL wormhole_c3: got %b/%h want 01000/0018", grant, xbar_sel);
    end
    vectors++;
    if (err_order !== 5'd0) begin
      miscompares++;
      $display("FAIL wormhole_no_err: got %b want 0", err_order);
    end
    next_cycle();
    req_valid = 5'd0;
  endtask

  task automatic test_backpressure();
    int bad_grants;
    int bad_tmo;
    bad_grants = 0;
    bad_tmo = 0;
    do_reset();
    set_req(0, 3'd4, 2'b00);
    next_cycle();
    set_req(0, 3'd4, 2'b01);
    out_ready = 5'b01111;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (grant !== 5'd0) bad_grants++;
      if (lock_tmo !== 5'd0) bad_tmo++;
      next_cycle();
    end
    vectors++;
    if (bad_grants != 0) begin
      miscompares++;
      $display("FAIL backpressure_grants: got %0d granted cycles want 0", bad_grants);
    end
    vectors++;
    if (bad_tmo != 0) begin
      miscompares++;
      $display("FAIL backpressure_tmo: got %0d pulse cycles want 0", bad_tmo);
    end
    out_ready = 5'h1F;
    #1;
    vectors++;
    if (grant !== 5'b00001 || xbar_sel !== 15'h0000 || xbar_valid !== 5'b10000) begin
      miscompares++;
      $display("FAIL backpressure_lock_held: got %b/%b want 00001/10000", grant, xbar_valid);
    end
    next_cycle();
    req_valid = 5'd0;
  endtask

  task automatic test_timeout();
    do_reset();
    set_req(1, 3'd2, 2'b00);
    #1;
    vectors++;
    if (grant !== 5'b00010) begin
      miscompares++;
      $display("FAIL timeout_head: got %b want %b", grant, 5'b00010);
    end
    next_cycle();
    clr_req(1);
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      vectors++;
      if (lock_tmo !== 5'd0) begin
        miscompares++;
        $display("FAIL timeout_early_%0d: got %b want 0", k, lock_tmo);
      end
    end
    set_req(3, 3'd2, 2'b11);
    #1;
    vectors++;
    if (grant !== 5'd0) begin
      miscompares++;
      $display("FAIL timeout_still_locked: got %b want 0", grant);
    end
    next_cycle();
    vectors++;
    if (lock_tmo !== 5'b00100) begin
      miscompares++;
      $display("FAIL timeout_pulse: got %b want %b", lock_tmo, 5'b00100);
    end
    vectors++;
    if (grant !== 5'b01000) begin
      miscompares++;
      $display("FAIL timeout_released: got %b want %b", grant, 5'b01000);
    end
    next_cycle();
    req_valid = 5'd0;
    vectors++;
    if (lock_tmo !== 5'd0) begin
      miscompares++;
      $display("FAIL timeout_single_pulse: got %b want 0", lock_tmo);
    end
  endtask

  task automatic test_errors();
    do_reset();
    set_req(1, 3'd6, 2'b11);
    #1;
    vectors++;
    if (grant !== 5'd0 || xbar_valid !== 5'd0) begin
      miscompares++;
      $display("FAIL err_gate_nogrant: got %b/%b want 0/0", grant, xbar_valid);
    end
    next_cycle();
    clr_req(1);
    set_req(0, 3'd3, 2'b01);
    vectors++;
    if (err_gate !== 5'b00010) begin
      miscompares++;
      $display("FAIL err_gate_pulse: got %b want %b", err_gate, 5'b00010);
    end
    vectors++;
    if (grant !== 5'd0) begin
      miscompares++;
      $display("FAIL err_order_nogrant: got %b want 0", grant);
    end
    next_cycle();
    clr_req(0);
    vectors++;
    if (err_order !== 5'b00001 || err_gate !== 5'd0) begin
      miscompares++;
      $display("FAIL err_order_pulse: got %b/%b want 00001/00000", err_order, err_gate);
    end
    set_req(2, 3'd0, 2'b00);
    next_cycle();
    set_req(2, 3'd0, 2'b01);
    reset = 1'b1;
    #1;
    vectors++;
    if (grant !== 5'd0 || xbar_valid !== 5'd0 || xbar_sel !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_mid_packet: got %b/%b/%h want 0/0/0", grant, xbar_valid, xbar_sel);
    end
    next_cycle();
    reset = 1'b0;
    #1;
    vectors++;
    if (grant !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_drops_lock: got %b want 0", grant);
    end
    next_cycle();
    req_valid = 5'd0;
    vectors++;
    if (err_order !== 5'b00100) begin
      miscompares++;
      $display("FAIL reset_idle_err: got %b want %b", err_order, 5'b00100);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_wormhole();
    test_backpressure();
    test_timeout();
    test_errors();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
